// File: rtl/logic_pipe_pkg.sv
// Shared definitions for logic_pipe: operator encodings and the
// single-lane operator function that the top level applies bit by bit.
package logic_pipe_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NAND = 2'd0,
        OP_AND  = 2'd1,
        OP_XOR  = 2'd2,
        OP_NOR  = 2'd3
    } op_e;

    // One lane only; callers slice their buses so any WIDTH works.
    function automatic logic apply_op(input logic a, input logic b, input op_e op);
        logic r;
        unique case (op)
            OP_NAND: r = ~(a & b);
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register stage. It accepts new data whenever it is empty
// or its own contents are leaving downstream in the same cycle.
module logic_pipe_stage #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         dn_valid,
    output logic [W-1:0] dn_data,
    input  logic         dn_ready
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_valid && up_ready) begin
            dn_valid <= 1'b1;
            dn_data  <= up_data;
        end else if (dn_ready) begin
            dn_valid <= 1'b0;
        end
    end

    // A stalled stage must hold its contents untouched.
    assert property (@(posedge Clk)
        (dn_valid && !dn_ready && !Rst) |=> (dn_valid && $stable(dn_data)));

endmodule

// File: rtl/logic_pipe.sv
// Operand register, bitwise operator and DEPTH result stages with
// valid/ready flow control; used as a parametrised timing test datapath.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [WIDTH-1:0]           IN1,
    input  logic [WIDTH-1:0]           IN2,
    input  logic [OP_W-1:0]            OP,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           OUT,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);

    localparam int S0_W  = 2*WIDTH + OP_W;
    localparam int OCC_W = $clog2(DEPTH+2);

    logic [S0_W-1:0]  s0_data;
    logic             s0_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OP_W-1:0]  op_bits;
    logic [WIDTH-1:0] op_result;

    logic             vld [DEPTH];
    logic             rdy [DEPTH];
    logic [WIDTH-1:0] res [DEPTH];

    logic_pipe_stage #(.W(S0_W)) u_s0 (
        .Clk      (Clk),
        .Rst      (Rst),
        .up_valid (in_valid),
        .up_data  ({IN1, IN2, OP}),
        .up_ready (in_ready),
        .dn_valid (s0_valid),
        .dn_data  (s0_data),
        .dn_ready (rdy[0])
    );

    assign {op_a, op_b, op_bits} = s0_data;

    always_comb begin
        op_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            op_result[i] = apply_op(op_a[i], op_b[i], op_e'(op_bits));
        end
    end

    // Result stage k+1 lives at index k; the last one faces out_ready.
    for (genvar k = 0; k < DEPTH; k++) begin : g_res
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_r;

        if (k == 0) begin : g_first
            assign up_v = s0_valid;
            assign up_d = op_result;
        end else begin : g_mid
            assign up_v = vld[k-1];
            assign up_d = res[k-1];
        end

        if (k == DEPTH-1) begin : g_last
            assign dn_r = out_ready;
        end else begin : g_inner
            assign dn_r = rdy[k+1];
        end

        logic_pipe_stage #(.W(WIDTH)) u_stage (
            .Clk      (Clk),
            .Rst      (Rst),
            .up_valid (up_v),
            .up_data  (up_d),
            .up_ready (rdy[k]),
            .dn_valid (vld[k]),
            .dn_data  (res[k]),
            .dn_ready (dn_r)
        );
    end

    assign OUT       = res[DEPTH-1];
    assign out_valid = vld[DEPTH-1];

    always_comb begin
        occupancy = OCC_W'(s0_valid);
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(vld[k]);
        end
    end

    assert property (@(posedge Clk) disable iff (Rst)
        (32'(occupancy) <= DEPTH + 1));

endmodule
